// File: rtl/morse_pkg.sv
// Shared Morse scheduler definitions: letter/pattern widths, FSM states and the
// letter-to-pattern lookup used when a queued letter is loaded for transmission.
package morse_pkg;

  localparam int LETTER_W  = 3;
  localparam int PATTERN_W = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Patterns are sent MSB first; each 1 is a tone bit period, each 0 silence.
  function automatic logic [PATTERN_W-1:0] letterPattern(input logic [LETTER_W-1:0] letter);
    logic [PATTERN_W-1:0] pat;
    case (letter)
      3'd0:    pat = 12'b101110000000;
      3'd1:    pat = 12'b111010101000;
      3'd2:    pat = 12'b111010111010;
      3'd3:    pat = 12'b111010100000;
      3'd4:    pat = 12'b100000000000;
      3'd5:    pat = 12'b101011101000;
      3'd6:    pat = 12'b111011101000;
      default: pat = 12'b101010100000;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/morse_letter_fifo.sv
// Letter queue between the request arbiter and the Morse sender: wrap-around
// pointers plus an occupancy count so full/empty are unambiguous.
module morse_letter_fifo
  import morse_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                i_ClockIn,
  input  logic                i_Reset,
  input  logic                i_push,
  input  logic                i_pop,
  input  logic [LETTER_W-1:0] i_din,
  output logic [LETTER_W-1:0] o_dout,
  output logic                o_full,
  output logic                o_empty
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [LETTER_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    r_wrPtr;
  logic [PTR_W-1:0]    r_rdPtr;
  logic [CNT_W-1:0]    r_count;
  logic                w_doPush;
  logic                w_doPop;

  assign o_full   = (r_count == CNT_W'(FIFO_DEPTH));
  assign o_empty  = (r_count == '0);
  assign o_dout   = r_mem[r_rdPtr];
  assign w_doPush = i_push && !o_full;
  assign w_doPop  = i_pop && !o_empty;

  always_ff @(posedge i_ClockIn) begin
    if (w_doPush) begin
      r_mem[r_wrPtr] <= i_din;
    end
  end

  always_ff @(posedge i_ClockIn) begin
    if (i_Reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) begin
        r_wrPtr <= (r_wrPtr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_wrPtr + 1'b1;
      end
      if (w_doPop) begin
        r_rdPtr <= (r_rdPtr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_rdPtr + 1'b1;
      end
      // A push and pop in the same cycle cancel out in the occupancy.
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/morse_msg_scheduler.sv
// Two-requester Morse letter scheduler: round-robin arbiter into a letter FIFO,
// then an IDLE/SEND/GAP sender that shifts each 12-bit pattern out at the bit rate.
module morse_msg_scheduler
  import morse_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = 500,
  parameter int FIFO_DEPTH      = 4,
  parameter int GAP_BITS        = 3
) (
  input  logic                i_ClockIn,
  input  logic                i_Reset,
  input  logic                i_ReqA,
  input  logic                i_ReqB,
  input  logic [LETTER_W-1:0] i_LetterA,
  input  logic [LETTER_W-1:0] i_LetterB,
  output logic                o_GntA,
  output logic                o_GntB,
  output logic                o_Full,
  output logic                o_Busy,
  output logic                o_DotDashOut,
  output logic                o_NewBitOut
);

  localparam int BIT_CYCLES = CLOCK_FREQUENCY / 2;
  localparam int GAP_CYCLES = GAP_BITS * BIT_CYCLES;
  localparam int RATE_W     = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int GAP_W      = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int BITCNT_W   = $clog2(PATTERN_W + 1);

  localparam logic [RATE_W-1:0] RATE_LOAD = RATE_W'(BIT_CYCLES - 1);
  localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'(GAP_CYCLES - 1);

  state_t                r_state;
  logic [PATTERN_W-1:0]  r_shiftReg;
  logic [BITCNT_W-1:0]   r_bitCount;
  logic [RATE_W-1:0]     r_rateCount;
  logic [GAP_W-1:0]      r_gapCount;
  logic                  r_dotDash;
  logic                  r_newBit;
  logic                  r_lastGntB;

  logic                  w_gntA;
  logic                  w_gntB;
  logic                  w_push;
  logic                  w_pop;
  logic [LETTER_W-1:0]   w_pushLetter;
  logic [LETTER_W-1:0]   w_fifoDout;
  logic                  w_fifoFull;
  logic                  w_fifoEmpty;

  // Full is the pre-pop occupancy, so a cycle that pops a full FIFO grants nothing.
  always_comb begin
    w_gntA = 1'b0;
    w_gntB = 1'b0;
    if (!i_Reset && !w_fifoFull) begin
      if (i_ReqA && i_ReqB) begin
        if (r_lastGntB) begin
          w_gntA = 1'b1;
        end else begin
          w_gntB = 1'b1;
        end
      end else if (i_ReqA) begin
        w_gntA = 1'b1;
      end else if (i_ReqB) begin
        w_gntB = 1'b1;
      end
    end
  end

  assign w_push       = w_gntA || w_gntB;
  assign w_pushLetter = w_gntA ? i_LetterA : i_LetterB;
  assign w_pop        = (r_state == IDLE) && !w_fifoEmpty;

  morse_letter_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .i_ClockIn(i_ClockIn),
    .i_Reset  (i_Reset),
    .i_push   (w_push),
    .i_pop    (w_pop),
    .i_din    (w_pushLetter),
    .o_dout   (w_fifoDout),
    .o_full   (w_fifoFull),
    .o_empty  (w_fifoEmpty)
  );

  // Tone and bit-strobe are registered views of the SEND state, so both lag the
  // shift register by one cycle and stay aligned with each other.
  always_ff @(posedge i_ClockIn) begin
    if (i_Reset) begin
      r_state     <= IDLE;
      r_shiftReg  <= '0;
      r_bitCount  <= '0;
      r_rateCount <= '0;
      r_gapCount  <= '0;
      r_dotDash   <= 1'b0;
      r_newBit    <= 1'b0;
      r_lastGntB  <= 1'b1;
    end else begin
      if (w_push) begin
        r_lastGntB <= w_gntB;
      end
      r_dotDash <= (r_state == SEND) && r_shiftReg[PATTERN_W-1];
      r_newBit  <= (r_state == SEND) && (r_rateCount == '0);
      case (r_state)
        IDLE: begin
          if (!w_fifoEmpty) begin
            r_shiftReg  <= letterPattern(w_fifoDout);
            r_bitCount  <= BITCNT_W'(PATTERN_W);
            r_rateCount <= RATE_LOAD;
            r_state     <= SEND;
          end
        end
        SEND: begin
          if (r_rateCount == '0) begin
            r_shiftReg  <= {r_shiftReg[PATTERN_W-2:0], 1'b0};
            r_bitCount  <= r_bitCount - 1'b1;
            r_rateCount <= RATE_LOAD;
            if (r_bitCount == BITCNT_W'(1)) begin
              r_gapCount <= GAP_LOAD;
              r_state    <= GAP;
            end
          end else begin
            r_rateCount <= r_rateCount - 1'b1;
          end
        end
        GAP: begin
          if (r_gapCount == '0) begin
            r_state <= IDLE;
          end else begin
            r_gapCount <= r_gapCount - 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_GntA       = w_gntA;
  assign o_GntB       = w_gntB;
  assign o_Full       = w_fifoFull;
  assign o_Busy       = !w_fifoEmpty || (r_state != IDLE);
  assign o_DotDashOut = r_dotDash;
  assign o_NewBitOut  = r_newBit;

endmodule

// File: tb/tb_morse_msg_scheduler.sv
// Self-checking bench for morse_msg_scheduler: a scoreboard of expected Morse bits
// is checked at every NewBitOut strobe, alongside directed cycle-level checks.
module tb_morse_msg_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       reqA, reqB;
  logic [2:0] letA, letB;
  logic       gntA, gntB, full, busy, dd, nb;

  int total = 0;
  int bad   = 0;

  logic expQ[$];

  localparam logic [11:0] PAT [8] = '{
    12'b101110000000, 12'b111010101000, 12'b111010111010, 12'b111010100000,
    12'b100000000000, 12'b101011101000, 12'b111011101000, 12'b101010100000
  };

  always #5 clk = ~clk;

  morse_msg_scheduler #(
    .CLOCK_FREQUENCY(8),
    .FIFO_DEPTH     (4),
    .GAP_BITS       (3)
  ) dut (
    .i_ClockIn   (clk),
    .i_Reset     (rst),
    .i_ReqA      (reqA),
    .i_ReqB      (reqB),
    .i_LetterA   (letA),
    .i_LetterB   (letB),
    .o_GntA      (gntA),
    .o_GntB      (gntB),
    .o_Full      (full),
    .o_Busy      (busy),
    .o_DotDashOut(dd),
    .o_NewBitOut (nb)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic ra, input logic [2:0] la, input logic rb, input logic [2:0] lb);
    reqA = ra;
    letA = la;
    reqB = rb;
    letB = lb;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic expectLetter(input logic [2:0] l);
    logic [11:0] p;
    p = PAT[l];
    for (int i = 11; i >= 0; i--) expQ.push_back(p[i]);
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(1'b0, 3'd0, 1'b0, 3'd0);
    repeat (2) stepCycle();
    rst = 1'b0;
    expQ.delete();
  endtask

  // Expected tone for a letter whose first bit appears on cycle 'start'.
  function automatic logic expDd(input int k, input logic [11:0] p, input int start);
    if (k >= start && k < start + 48) return p[11 - (k - start) / 4];
    return 1'b0;
  endfunction

  function automatic logic expNb(input int k, input int start);
    return (k >= start) && (k < start + 48) && (((k - start) % 4) == 3);
  endfunction

  // Scoreboard monitor: every bit strobe consumes one expected bit.
  always @(negedge clk) begin
    logic expBit;
    if (!rst && nb === 1'b1) begin
      checkOutput("sb_has_expected", 32'(expQ.size() != 0), 1);
      if (expQ.size() != 0) begin
        expBit = expQ.pop_front();
        checkOutput("sb_bit", 32'(dd), 32'(expBit));
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int viol, released, pulses, tones;
    rst = 1'b1;
    applyStimulus(1'b0, 3'd0, 1'b0, 3'd0);
    repeat (2) stepCycle();

    // Reset state, with a request held to confirm grants are suppressed.
    applyStimulus(1'b1, 3'd4, 1'b0, 3'd0);
    @(negedge clk);
    checkOutput("rst_gntA", 32'(gntA), 0);
    checkOutput("rst_dd", 32'(dd), 0);
    checkOutput("rst_nb", 32'(nb), 0);
    checkOutput("rst_full", 32'(full), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    stepCycle();
    rst = 1'b0;
    applyStimulus(1'b0, 3'd0, 1'b0, 3'd0);
    expQ.delete();

    $display("[TB] single letter E");
    applyStimulus(1'b1, 3'd4, 1'b0, 3'd0);
    expectLetter(3'd4);
    @(negedge clk);
    checkOutput("e_gntA", 32'(gntA), 1);
    checkOutput("e_gntB", 32'(gntB), 0);
    stepCycle();
    applyStimulus(1'b0, 3'd0, 1'b0, 3'd0);
    for (int k = 0; k <= 65; k++) begin
      @(negedge clk);
      checkOutput($sformatf("e_dd@%0d", k), 32'(dd), 32'(expDd(k, PAT[4], 2)));
      checkOutput($sformatf("e_nb@%0d", k), 32'(nb), 32'(expNb(k, 2)));
      checkOutput($sformatf("e_busy@%0d", k), 32'(busy), 32'(k <= 60));
    end

    $display("[TB] letters A then E");
    stepCycle();
    applyStimulus(1'b1, 3'd0, 1'b0, 3'd0);
    expectLetter(3'd0);
    @(negedge clk);
    checkOutput("ae_gnt0", 32'(gntA), 1);
    stepCycle();
    applyStimulus(1'b1, 3'd4, 1'b0, 3'd0);
    expectLetter(3'd4);
    @(negedge clk);
    checkOutput("ae_gnt1", 32'(gntA), 1);
    stepCycle();
    applyStimulus(1'b0, 3'd0, 1'b0, 3'd0);
    for (int k = 1; k <= 67; k++) begin
      @(negedge clk);
      checkOutput($sformatf("ae_dd@%0d", k), 32'(dd),
                  32'(expDd(k, PAT[0], 2) | expDd(k, PAT[4], 63)));
      checkOutput($sformatf("ae_nb@%0d", k), 32'(nb), 32'(expNb(k, 2) | expNb(k, 63)));
    end
    for (int c = 0; c < 200 && busy; c++) @(negedge clk);
    checkOutput("ae_idle", 32'(busy), 0);

    $display("[TB] round-robin fill and full release");
    doReset();
    applyStimulus(1'b1, 3'd1, 1'b1, 3'd2);
    for (int i = 0; i < 5; i++) begin
      logic expA;
      expA = ((i % 2) == 0);
      @(negedge clk);
      checkOutput($sformatf("rr_gntA%0d", i), 32'(gntA), 32'(expA));
      checkOutput($sformatf("rr_gntB%0d", i), 32'(gntB), 32'(!expA));
      checkOutput($sformatf("rr_full%0d", i), 32'(full), 0);
      expectLetter(expA ? 3'd1 : 3'd2);
      stepCycle();
    end
    @(negedge clk);
    checkOutput("rr_full_set", 32'(full), 1);
    checkOutput("rr_full_gnt", 32'(gntA | gntB), 0);
    viol = 0;
    released = 0;
    for (int c = 0; c < 200 && released == 0; c++) begin
      stepCycle();
      @(negedge clk);
      if (!full) released = 1;
      else if (gntA || gntB) viol++;
    end
    checkOutput("full_no_grant", 32'(viol), 0);
    checkOutput("full_release_seen", 32'(released), 1);
    checkOutput("release_gntB", 32'(gntB), 1);
    checkOutput("release_gntA", 32'(gntA), 0);
    expectLetter(3'd2);
    stepCycle();
    applyStimulus(1'b0, 3'd0, 1'b0, 3'd0);
    @(negedge clk);
    checkOutput("refull", 32'(full), 1);
    for (int c = 0; c < 800 && busy; c++) @(negedge clk);
    checkOutput("drain_idle", 32'(busy), 0);
    checkOutput("sb_drained", 32'(expQ.size()), 0);

    $display("[TB] reset mid-letter");
    doReset();
    applyStimulus(1'b1, 3'd1, 1'b0, 3'd0);
    @(negedge clk);
    checkOutput("mr_gnt0", 32'(gntA), 1);
    expectLetter(3'd1);
    stepCycle();
    applyStimulus(1'b1, 3'd3, 1'b1, 3'd5);
    @(negedge clk);
    checkOutput("mr_gnt1", 32'(gntB), 1);
    expectLetter(3'd5);
    stepCycle();
    @(negedge clk);
    checkOutput("mr_gnt2", 32'(gntA), 1);
    expectLetter(3'd3);
    stepCycle();
    applyStimulus(1'b0, 3'd0, 1'b0, 3'd0);
    pulses = 0;
    for (int c = 0; c < 100 && pulses < 4; c++) begin
      @(negedge clk);
      if (nb) pulses++;
    end
    checkOutput("mr_bits_before", 32'(pulses), 4);
    stepCycle();
    rst = 1'b1;
    @(negedge clk);
    checkOutput("mr_tone_bit5", 32'(dd), 1);
    stepCycle();
    rst = 1'b0;
    expQ.delete();
    @(negedge clk);
    checkOutput("mr_dd", 32'(dd), 0);
    checkOutput("mr_nb", 32'(nb), 0);
    checkOutput("mr_busy", 32'(busy), 0);
    checkOutput("mr_full", 32'(full), 0);
    tones = 0;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      if (dd || nb || busy) tones++;
    end
    checkOutput("mr_silent", 32'(tones), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
